uart_tx_arbiter: RTL
====================

// Module: uart_tx_arbiter
// PURPOSE
//   Shares one UartT transmitter between NREQ byte-stream requesters.
//   Round-robin grant at message granularity. The owner keeps the grant
//   until its byte flagged last has fully drained from the UART.
//   Sits between on-chip producers (console, debug, test-pattern
//   generators) and uart0. Replaces the free-running ~busy enable loop.
// PARAMETERS
//   NREQ      4    number of requesters (>=2); GW = $clog2(NREQ)
//   HOLD_MAX  16   idle cycles allowed in LOAD before grant is revoked (0 = never)
//   HOLD_W    8    width of hold-timeout counter (2**HOLD_W > HOLD_MAX)
//   CNT_W     16   width of sent-byte counter
// PORTS
//   clk          in   1        clock
//   rst          in   1        async reset, active-high
//   req_valid_i  in   NREQ     byte valid, one bit per requester
//   req_last_i   in   NREQ     byte is last of message; sampled with valid
//   req_data_i   in   NREQ*8   requester i byte at [8i+7:8i]
//   req_ready_o  out  NREQ     byte accepted when valid&ready (one-hot or 0)
//   uart_data_o  out  8        byte to UartT data_i; stable from SEND to next LOAD
//   uart_en_o    out  1        to UartT en_i
//   uart_busy_i  in   1        from UartT busy_o
//   grant_o      out  GW       current/last owner index
//   active_o     out  1        a message is in progress (state != IDLE)
//   abort_o      out  1        1-cycle pulse: grant revoked by hold timeout
//   sent_cnt_o   out  CNT_W    bytes handed to UART, wraps modulo 2**CNT_W
// BEHAVIOUR
//   Reset (async, immediate): state=IDLE, ptr=NREQ-1, all outputs 0,
//     data_q=0, last_q=0, hold counter=0. Reset mid-message drops en at once.
//     The UART byte already in flight is not tracked.
//   FSM states: IDLE, LOAD, SEND, DRAIN.
//   IDLE: if |req_valid_i, winner = first set bit scanning ptr+1, ptr+2 ..
//     mod NREQ. Register grant_o = ptr = winner and go to LOAD.
//     No valid: stay in IDLE.
//   LOAD: req_ready_o[grant]=1 regardless of valid.
//     On valid[grant]: data_q<=byte, last_q<=last, hold counter clears,
//     sent_cnt++, and go to SEND.
//     No valid: hold counter increments.
//     Counter == HOLD_MAX (HOLD_MAX!=0): abort_o=1 for one cycle, grant is
//     released, go to IDLE. ptr stays at the aborted owner, so it gets
//     lowest priority next.
//   SEND: uart_en_o=1 and uart_data_o=data_q. Once uart_busy_i==1 is
//     sampled, en drops the next cycle and the FSM goes to DRAIN.
//     No timeout here.
//   DRAIN: uart_en_o=0. Wait for uart_busy_i==0. Then go to IDLE if last_q,
//     else back to LOAD with the same owner.
//   Latency: valid seen in IDLE at cycle 0 -> ready at cycle 1 ->
//     uart_en_o at cycle 2.
//   Non-owners never see ready. Their valid/data are ignored mid-message.
//   Requesters hold valid/data/last stable until accepted.
//   Simultaneous requests in IDLE: only the round-robin winner is granted.
//     Others wait with no loss.
//   uart_busy_i already 1 on SEND entry: advance to DRAIN after one en cycle.
//     The byte is counted as sent.
//   sent_cnt_o wraps from 2**CNT_W-1 to 0 with no flag.
// TESTING
//   1 Req0 sends 0x41, last=1, UART model busy 10 cycles -> ready0 at cyc1;
//     en=1, data=0x41 from cyc2 until busy; active_o=0 after drain;
//     sent_cnt_o=1.
//   2 Req0 and req2 each send 1 byte at once -> grants 0 then 2.
//     Then req0, req1 and req3 send at once -> order 3, 0, 1.
//   3 Req1 sends 0x10, 0x11, 0x12 (last on 0x12); req0 valid throughout ->
//     UART sees 10, 11, 12 contiguous, then req0's byte.
//     ready0 stays 0 until req1 drains.
//   4 HOLD_MAX=4: req3 sends 0x55 with last=0, then drops valid ->
//     abort_o pulses once 4 cycles into LOAD; IDLE; a pending req3 is served
//     after the other requesters.
//   5 Assert rst while in SEND with en=1 -> all outputs 0 in the same cycle.
//     After release, req0 and req3 both valid -> req0 granted first.
//   6 CNT_W=4: send 17 single-byte messages -> sent_cnt_o goes 15 -> 0 -> 1.
//     Every byte matches in order at the UART model.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter between NREQ byte-stream
// requesters; the grant is held for a whole message until its last byte drains.
module uart_tx_arbiter #(
   parameter int NREQ     = 4,
   parameter int HOLD_MAX = 16,
   parameter int HOLD_W   = 8,
   parameter int CNT_W    = 16,
   localparam int GW      = $clog2(NREQ)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [NREQ-1:0]   req_valid_i,
   input  logic [NREQ-1:0]   req_last_i,
   input  logic [NREQ*8-1:0] req_data_i,
   output logic [NREQ-1:0]   req_ready_o,
   output logic [7:0]        uart_data_o,
   output logic              uart_en_o,
   input  logic              uart_busy_i,
   output logic [GW-1:0]     grant_o,
   output logic              active_o,
   output logic              abort_o,
   output logic [CNT_W-1:0]  sent_cnt_o
);

   // Handshake: a byte moves from requester i when req_valid_i[i] and
   // req_ready_o[i] are both high at a rising clk edge; ready is only ever
   // raised for the current owner, so at most one bit is set.

   typedef enum logic [1:0] {IDLE, LOAD, SEND, DRAIN} state_t;

   state_t              state;
   logic [GW-1:0]       ptr;
   logic [GW-1:0]       winner;
   logic [GW-1:0]       scan_idx;
   logic [7:0]          data_q;
   logic                last_q;
   logic [HOLD_W-1:0]   hold_cnt;
   logic [7:0]          sel_data;
   logic                sel_valid;
   logic                sel_last;

   // Scan from farthest to nearest so the requester closest after ptr wins.
   always_comb begin
      winner   = ptr;
      scan_idx = '0;
      for (int k = NREQ; k >= 1; k--) begin
         scan_idx = GW'((int'(ptr) + k) % NREQ);
         if (req_valid_i[scan_idx]) winner = scan_idx;
      end
   end

   always_comb begin
      sel_data = 8'h00;
      for (int i = 0; i < NREQ; i++) begin
         if (grant_o == GW'(i)) sel_data = req_data_i[8*i +: 8];
      end
      sel_valid = req_valid_i[grant_o];
      sel_last  = req_last_i[grant_o];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         ptr         <= GW'(NREQ - 1);
         grant_o     <= '0;
         req_ready_o <= '0;
         uart_en_o   <= 1'b0;
         abort_o     <= 1'b0;
         sent_cnt_o  <= '0;
         data_q      <= 8'h00;
         last_q      <= 1'b0;
         hold_cnt    <= '0;
      end else begin
         abort_o <= 1'b0;
         case (state)
            IDLE: begin
               if (|req_valid_i) begin
                  grant_o     <= winner;
                  ptr         <= winner;
                  req_ready_o <= NREQ'(1) << winner;
                  state       <= LOAD;
               end
            end
            LOAD: begin
               if (sel_valid) begin
                  data_q      <= sel_data;
                  last_q      <= sel_last;
                  hold_cnt    <= '0;
                  sent_cnt_o  <= sent_cnt_o + 1'b1;
                  req_ready_o <= '0;
                  uart_en_o   <= 1'b1;
                  state       <= SEND;
               end else if (HOLD_MAX != 0 && hold_cnt == HOLD_W'(HOLD_MAX - 1)) begin
                  // Idle count reaches HOLD_MAX this cycle; ptr stays on the
                  // aborted owner so it drops to lowest priority.
                  abort_o     <= 1'b1;
                  hold_cnt    <= '0;
                  req_ready_o <= '0;
                  state       <= IDLE;
               end else if (HOLD_MAX != 0) begin
                  hold_cnt <= hold_cnt + 1'b1;
               end
            end
            SEND: begin
               if (uart_busy_i) begin
                  uart_en_o <= 1'b0;
                  state     <= DRAIN;
               end
            end
            DRAIN: begin
               if (!uart_busy_i) begin
                  if (last_q) begin
                     state <= IDLE;
                  end else begin
                     req_ready_o <= NREQ'(1) << grant_o;
                     state       <= LOAD;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign uart_data_o = data_q;
   assign active_o    = (state != IDLE);

endmodule
